// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: UI sequencer for the clock/alarm/stopwatch display.
// Turns debounced button levels into edge/hold events, runs the view/setting
// state machine and drives counter, alarm, stopwatch and display-mux controls.
// Optional feature: define AUTO_RETURN_EN to leave setting states after
// TIMEOUT_MS ticks without a button edge.
module clock_mode_ctrl #(
  parameter int unsigned HOLD_MS    = 700,
  parameter int unsigned REPEAT_MS  = 150,
  parameter int unsigned BLINK_MS   = 500,
  parameter int unsigned TIMEOUT_MS = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_ms,
  input  logic       set,
  input  logic       sw,
  input  logic       inc_short,
  input  logic       inc_long,
  output logic       counter_enable,
  output logic [1:0] mux,
  output logic       mux_outmode,
  output logic       time_setting_enable,
  output logic       time_hr_or_min,
  output logic       regalarm_setting_enable,
  output logic       regalarm_hr_or_min,
  output logic       inc_pulse,
  output logic       sw_run,
  output logic       sw_clear,
  output logic       blink
);

  localparam int unsigned HOLD_W  = $clog2(HOLD_MS + REPEAT_MS + 1);
  localparam int unsigned BLINK_W = $clog2(BLINK_MS + 1);

  // Bit 2 marks a setting state, bit 1 splits time/alarm, bit 0 is the minute field.
  localparam logic [2:0] TIME_HM  = 3'd0;
  localparam logic [2:0] TIME_MS  = 3'd1;
  localparam logic [2:0] ALM_VIEW = 3'd2;
  localparam logic [2:0] SW_VIEW  = 3'd3;
  localparam logic [2:0] SET_HR   = 3'd4;
  localparam logic [2:0] SET_MIN  = 3'd5;
  localparam logic [2:0] ALM_HR   = 3'd6;
  localparam logic [2:0] ALM_MIN  = 3'd7;

  logic set_q, sw_q, inc_short_q, inc_long_q;
  logic set_e, sw_e, inc_short_e, inc_long_e, any_edge;
  logic [2:0] state_q, state_d;
  logic setting, timeout_hit, repeat_hit;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic blink_d;

  assign set_e       = set & ~set_q;
  assign sw_e        = sw & ~sw_q;
  assign inc_short_e = inc_short & ~inc_short_q;
  assign inc_long_e  = inc_long & ~inc_long_q;
  assign any_edge    = set_e | sw_e | inc_short_e | inc_long_e;
  assign setting     = state_q[2];

`ifdef AUTO_RETURN_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_MS + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Idle-tick counter for setting states; any button edge restarts it.
  always_comb begin
    to_cnt_d    = to_cnt_q;
    timeout_hit = 1'b0;
    if (!setting || any_edge) begin
      to_cnt_d = '0;
    end else if (tick_ms) begin
      if (to_cnt_q == TO_W'(TIMEOUT_MS - 1)) begin
        timeout_hit = 1'b1;
        to_cnt_d    = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state: set beats sw; a set edge also beats a coincident timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TIME_HM:  if (set_e) state_d = SET_HR; else if (sw_e) state_d = TIME_MS;
      TIME_MS:  if (set_e) state_d = SET_HR; else if (sw_e) state_d = ALM_VIEW;
      ALM_VIEW: if (set_e) state_d = ALM_HR; else if (sw_e) state_d = SW_VIEW;
      SW_VIEW:  if (!set_e && sw_e) state_d = TIME_HM;
      SET_HR:   if (set_e) state_d = SET_MIN;  else if (timeout_hit) state_d = TIME_HM;
      SET_MIN:  if (set_e) state_d = TIME_HM;  else if (timeout_hit) state_d = TIME_HM;
      ALM_HR:   if (set_e) state_d = ALM_MIN;  else if (timeout_hit) state_d = ALM_VIEW;
      ALM_MIN:  if (set_e) state_d = ALM_VIEW; else if (timeout_hit) state_d = ALM_VIEW;
      default:  state_d = TIME_HM;
    endcase
  end

  // inc_long hold counter: first repeat at HOLD_MS ticks, then every REPEAT_MS.
  always_comb begin
    hold_d     = hold_q;
    repeat_hit = 1'b0;
    if (!setting || !inc_long || (state_d != state_q)) begin
      hold_d = '0;
    end else if (tick_ms) begin
      if (hold_q == HOLD_W'(HOLD_MS + REPEAT_MS - 1)) begin
        repeat_hit = 1'b1;
        hold_d     = HOLD_W'(HOLD_MS);
      end else begin
        hold_d     = hold_q + 1'b1;
        repeat_hit = (hold_q == HOLD_W'(HOLD_MS - 1));
      end
    end
  end

  // Blink phase: restarts high on every state change, free-runs while setting.
  always_comb begin
    blink_d     = blink;
    blink_cnt_d = blink_cnt_q;
    if (!state_d[2] || (state_d != state_q)) begin
      blink_d     = 1'b1;
      blink_cnt_d = '0;
    end else if (tick_ms) begin
      if (blink_cnt_q == BLINK_W'(BLINK_MS - 1)) begin
        blink_d     = ~blink;
        blink_cnt_d = '0;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // State, edge history, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_q                   <= 1'b0;
      sw_q                    <= 1'b0;
      inc_short_q             <= 1'b0;
      inc_long_q              <= 1'b0;
      state_q                 <= TIME_HM;
      hold_q                  <= '0;
      blink_cnt_q             <= '0;
      counter_enable          <= 1'b1;
      mux                     <= 2'b00;
      mux_outmode             <= 1'b0;
      time_setting_enable     <= 1'b0;
      time_hr_or_min          <= 1'b0;
      regalarm_setting_enable <= 1'b0;
      regalarm_hr_or_min      <= 1'b0;
      inc_pulse               <= 1'b0;
      sw_run                  <= 1'b0;
      sw_clear                <= 1'b0;
      blink                   <= 1'b1;
    end else begin
      set_q                   <= set;
      sw_q                    <= sw;
      inc_short_q             <= inc_short;
      inc_long_q              <= inc_long;
      state_q                 <= state_d;
      hold_q                  <= hold_d;
      blink_cnt_q             <= blink_cnt_d;
      counter_enable          <= !(state_d == SET_HR || state_d == SET_MIN);
      mux                     <= (state_d == SW_VIEW) ? 2'b11 :
                                 (state_d == ALM_VIEW || state_d[2:1] == 2'b11) ? 2'b10 : 2'b00;
      mux_outmode             <= (state_d == TIME_MS) || (state_d == SW_VIEW);
      time_setting_enable     <= (state_d == SET_HR) || (state_d == SET_MIN);
      time_hr_or_min          <= (state_d == SET_MIN);
      regalarm_setting_enable <= (state_d == ALM_HR) || (state_d == ALM_MIN);
      regalarm_hr_or_min      <= (state_d == ALM_MIN);
      inc_pulse               <= setting & (inc_short_e | inc_long_e | repeat_hit);
      sw_clear                <= (state_q == SW_VIEW) & inc_long_e & ~sw_run;
      if ((state_q == SW_VIEW) && set_e) sw_run <= ~sw_run;
      blink                   <= blink_d;
    end
  end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl: expected inc_pulse/sw_clear strobes are queued when
// stimulus is driven and popped as the DUT emits them; levels are checked inline.
module tb_clock_mode_ctrl;
  logic clk = 1'b0;
  logic rst, tick_ms, set, sw, inc_short, inc_long;
  logic counter_enable, mux_outmode, time_setting_enable, time_hr_or_min;
  logic regalarm_setting_enable, regalarm_hr_or_min, inc_pulse, sw_run, sw_clear, blink;
  logic [1:0] mux;

  clock_mode_ctrl #(.HOLD_MS(4), .REPEAT_MS(2), .BLINK_MS(3), .TIMEOUT_MS(20)) dut (
    .clk(clk), .rst(rst), .tick_ms(tick_ms), .set(set), .sw(sw),
    .inc_short(inc_short), .inc_long(inc_long), .counter_enable(counter_enable),
    .mux(mux), .mux_outmode(mux_outmode), .time_setting_enable(time_setting_enable),
    .time_hr_or_min(time_hr_or_min), .regalarm_setting_enable(regalarm_setting_enable),
    .regalarm_hr_or_min(regalarm_hr_or_min), .inc_pulse(inc_pulse), .sw_run(sw_run),
    .sw_clear(sw_clear), .blink(blink)
  );

  always #5 clk = ~clk;

  // {clear strobe, time set enable, alarm set enable, field of active setting}
  typedef struct packed {logic clr; logic tse; logic ase; logic hm;} exp_t;
  localparam exp_t PulseTimeHr  = 4'b0100;
  localparam exp_t PulseTimeMin = 4'b0101;
  localparam exp_t PulseAlmMin  = 4'b0011;
  localparam exp_t PulseClear   = 4'b1000;
  localparam logic [11:0] ResetVec = 12'b1_00_0_0_0_0_0_0_0_0_1;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  function automatic logic [11:0] outs();
    return {counter_enable, mux, mux_outmode, time_setting_enable, time_hr_or_min,
            regalarm_setting_enable, regalarm_hr_or_min, inc_pulse, sw_run, sw_clear, blink};
  endfunction

  // One clock; any strobe seen is matched against the scoreboard head.
  task automatic cyc();
    exp_t got, e;
    @(posedge clk);
    #1;
    if (inc_pulse || sw_clear) begin
      got = {sw_clear, time_setting_enable, regalarm_setting_enable,
             time_setting_enable ? time_hr_or_min : regalarm_hr_or_min};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL strobe_unexpected got=%b want=none", got);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL strobe_fields got=%b want=%b", got, e);
        end
      end
    end
  endtask

  // which: 0 set, 1 sw, 2 inc_short, 3 inc_long
  task automatic press(input int which);
    case (which)
      0: set = 1'b1;
      1: sw = 1'b1;
      2: inc_short = 1'b1;
      default: inc_long = 1'b1;
    endcase
    cyc();
    set = 1'b0; sw = 1'b0; inc_short = 1'b0; inc_long = 1'b0;
    cyc();
  endtask

  task automatic ms(input int n);
    for (int i = 0; i < n; i++) begin
      tick_ms = 1'b1;
      cyc();
      tick_ms = 1'b0;
      cyc();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    total++;
    if (outs() !== ResetVec) begin
      bad++; $display("FAIL reset_outs got=%b want=%b", outs(), ResetVec);
    end
    rst = 1'b0;
    cyc();
    total++;
    if (outs() !== ResetVec) begin
      bad++; $display("FAIL reset_release got=%b want=%b", outs(), ResetVec);
    end
  endtask

  task automatic test_views();
    logic [2:0] want [4];
    want = '{3'b001, 3'b100, 3'b111, 3'b000};
    for (int i = 0; i < 4; i++) begin
      press(1);
      total++;
      if ({mux, mux_outmode, counter_enable} !== {want[i], 1'b1}) begin
        bad++;
        $display("FAIL view_%0d got=%b want=%b", i, {mux, mux_outmode, counter_enable},
                 {want[i], 1'b1});
      end
    end
  endtask

  task automatic test_time_set();
    press(0);
    total++;
    if ({time_setting_enable, time_hr_or_min, counter_enable} !== 3'b100) begin
      bad++; $display("FAIL set_hr_enter got=%b want=100",
                      {time_setting_enable, time_hr_or_min, counter_enable});
    end
    sb.push_back(PulseTimeHr); sb.push_back(PulseTimeHr);
    press(2); press(2);
    press(0);
    total++;
    if ({time_setting_enable, time_hr_or_min, counter_enable} !== 3'b110) begin
      bad++; $display("FAIL set_min_enter got=%b want=110",
                      {time_setting_enable, time_hr_or_min, counter_enable});
    end
    sb.push_back(PulseTimeMin);
    press(2);
    press(0);
    total++;
    if (outs() !== ResetVec) begin
      bad++; $display("FAIL set_exit got=%b want=%b", outs(), ResetVec);
    end
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL time_set_drain got=%0d want=0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_blink();
    press(0);
    ms(2);
    total++;
    if (blink !== 1'b1) begin bad++; $display("FAIL blink_2ticks got=%b want=1", blink); end
    ms(1);
    total++;
    if (blink !== 1'b0) begin bad++; $display("FAIL blink_3ticks got=%b want=0", blink); end
    ms(3);
    total++;
    if (blink !== 1'b1) begin bad++; $display("FAIL blink_6ticks got=%b want=1", blink); end
    ms(3);
    press(0);
    total++;
    if (blink !== 1'b1) begin bad++; $display("FAIL blink_restart got=%b want=1", blink); end
    press(0);
  endtask

  task automatic test_hold();
    press(0);
    inc_long = 1'b1;
    sb.push_back(PulseTimeHr);
    cyc();
    for (int t = 1; t <= 10; t++) begin
      if (t >= 4 && (t % 2) == 0) sb.push_back(PulseTimeHr);
      ms(1);
    end
    inc_long = 1'b0;
    cyc();
    ms(5);
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL hold_drain got=%0d want=0", sb.size()); sb.delete();
    end
    press(0); press(0);
  endtask

  task automatic test_stopwatch();
    press(1); press(1); press(1);
    press(0);
    total++;
    if ({mux, sw_run} !== 3'b111) begin
      bad++; $display("FAIL sw_start got=%b want=111", {mux, sw_run});
    end
    press(3);
    press(2);
    press(0);
    total++;
    if (sw_run !== 1'b0) begin bad++; $display("FAIL sw_stop got=%b want=0", sw_run); end
    sb.push_back(PulseClear);
    press(3);
    total++;
    if (sw_run !== 1'b0) begin bad++; $display("FAIL sw_clear_run got=%b want=0", sw_run); end
    press(0);
    press(1);
    total++;
    if ({mux, mux_outmode, sw_run} !== 4'b0001) begin
      bad++; $display("FAIL sw_persist got=%b want=0001", {mux, mux_outmode, sw_run});
    end
    press(1); press(1); press(1);
    press(0);
    press(1);
    total++;
    if (sb.size() != 0 || sw_run !== 1'b0) begin
      bad++; $display("FAIL sw_drain got=%0d/%b want=0/0", sb.size(), sw_run); sb.delete();
    end
  endtask

  task automatic test_coincident();
    set = 1'b1; sw = 1'b1;
    cyc();
    set = 1'b0; sw = 1'b0;
    cyc();
    total++;
    if ({time_setting_enable, mux, mux_outmode} !== 4'b1000) begin
      bad++; $display("FAIL set_beats_sw got=%b want=1000",
                      {time_setting_enable, mux, mux_outmode});
    end
    sb.push_back(PulseTimeHr);
    inc_short = 1'b1; inc_long = 1'b1;
    cyc();
    inc_short = 1'b0; inc_long = 1'b0;
    cyc(); cyc();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL coincident_drain got=%0d want=0", sb.size()); sb.delete();
    end
    press(0); press(0);
  endtask

  task automatic test_timeout();
    press(1); press(1);
    press(0);
    total++;
    if ({mux, regalarm_setting_enable, regalarm_hr_or_min, counter_enable} !== 5'b10101) begin
      bad++; $display("FAIL alm_hr_enter got=%b want=10101",
                      {mux, regalarm_setting_enable, regalarm_hr_or_min, counter_enable});
    end
    press(0);
    sb.push_back(PulseAlmMin);
    press(2);
`ifdef AUTO_RETURN_EN
    ms(19);
    total++;
    if ({regalarm_setting_enable, regalarm_hr_or_min} !== 2'b11) begin
      bad++; $display("FAIL timeout_early got=%b want=11",
                      {regalarm_setting_enable, regalarm_hr_or_min});
    end
    ms(1);
    total++;
    if ({mux, regalarm_setting_enable} !== 3'b100) begin
      bad++; $display("FAIL timeout_exit got=%b want=100", {mux, regalarm_setting_enable});
    end
`else
    ms(100);
    total++;
    if ({mux, regalarm_setting_enable, regalarm_hr_or_min} !== 4'b1011) begin
      bad++; $display("FAIL no_timeout got=%b want=1011",
                      {mux, regalarm_setting_enable, regalarm_hr_or_min});
    end
    press(0);
`endif
    press(1); press(1);
    total++;
    if (sb.size() != 0 || outs() !== ResetVec) begin
      bad++; $display("FAIL timeout_drain got=%0d/%b want=0/%b", sb.size(), outs(), ResetVec);
      sb.delete();
    end
  endtask

  task automatic test_reset_abort();
    press(0);
    inc_long = 1'b1;
    sb.push_back(PulseTimeHr);
    cyc();
    ms(3);
    rst = 1'b1;
    #1;
    total++;
    if (outs() !== ResetVec) begin
      bad++; $display("FAIL rst_abort got=%b want=%b", outs(), ResetVec);
    end
    ms(5);
    rst = 1'b0;
    ms(8);
    inc_long = 1'b0;
    cyc();
    total++;
    if (sb.size() != 0 || outs() !== ResetVec) begin
      bad++; $display("FAIL rst_abort_after got=%0d/%b want=0/%b", sb.size(), outs(), ResetVec);
      sb.delete();
    end
  endtask

  initial begin
    rst = 1'b1; tick_ms = 1'b0; set = 1'b0; sw = 1'b0; inc_short = 1'b0; inc_long = 1'b0;
    test_reset();
    test_views();
    test_time_set();
    test_blink();
    test_hold();
    test_stopwatch();
    test_coincident();
    test_timeout();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
